// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation SAD minimum selector.
package me_pkg;

    localparam int unsigned SUM_LATENCY = 5;
    localparam int unsigned SAD_W       = 16;
    localparam int unsigned MV_W        = 6;
    localparam int unsigned CNT_W       = 10;

    typedef struct packed {
        logic signed [MV_W-1:0] mvx;
        logic signed [MV_W-1:0] mvy;
    } mv_t;

    typedef struct packed {
        logic valid;
        mv_t  mv;
        logic last;
    } sad_tag_t;

    typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} sel_state_t;

    typedef logic [MV_W:0] cost_t;

    // |mvx| + |mvy| on MV_W+1 bits; the magnitude of the most negative value fits unsigned
    function automatic cost_t mv_cost(mv_t mv);
        logic [MV_W-1:0] ax;
        logic [MV_W-1:0] ay;
        ax = mv.mvx[MV_W-1] ? (~mv.mvx + 1'b1) : mv.mvx;
        ay = mv.mvy[MV_W-1] ? (~mv.mvy + 1'b1) : mv.mvy;
        return {1'b0, ax} + {1'b0, ay};
    endfunction

endpackage

// File: rtl/sad_min_select_if.sv
// Candidate input, SAD input and result handshake of the SAD minimum selector.
interface sad_min_select_if;
    import me_pkg::*;

    logic                   start;
    logic                   busy;
    logic                   cand_valid;
    logic signed [MV_W-1:0] cand_mvx;
    logic signed [MV_W-1:0] cand_mvy;
    logic                   cand_last;
    logic [SAD_W-1:0]       sad;
    logic                   best_valid;
    logic                   best_ready;
    logic signed [MV_W-1:0] best_mvx;
    logic signed [MV_W-1:0] best_mvy;
    logic [SAD_W-1:0]       best_sad;
    logic [CNT_W-1:0]       best_cnt;

    modport slave (
        input  start, cand_valid, cand_mvx, cand_mvy, cand_last, sad, best_ready,
        output busy, best_valid, best_mvx, best_mvy, best_sad, best_cnt
    );

    modport master (
        output start, cand_valid, cand_mvx, cand_mvy, cand_last, sad, best_ready,
        input  busy, best_valid, best_mvx, best_mvy, best_sad, best_cnt
    );

endinterface

// File: rtl/sad_tag_delay.sv
// Fixed-depth tag shift register matching the adder tree pipeline; never stalls.
module sad_tag_delay
    import me_pkg::*;
#(
    parameter int unsigned DEPTH = SUM_LATENCY
) (
    input  logic     clk,
    input  logic     rst_n,
    input  sad_tag_t tag_in,
    output sad_tag_t tag_out
);

    sad_tag_t line_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign tag_out = line_q[DEPTH-1];

endmodule

// File: rtl/sad_min_select.sv
// Tracks the minimum-SAD motion vector over one search and hands it out via valid/ready.
module sad_min_select
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    sad_min_select_if.slave  bus
);

    sel_state_t       state_q, state_d;
    mv_t              best_mv_q, best_mv_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic             first_q, first_d;
    logic             best_valid_q, best_valid_d;
    sad_tag_t         push_tag;
    sad_tag_t         dly_tag;
    logic             better;

    always_comb begin
        push_tag = '0;
        if (state_q == SEARCH && bus.cand_valid) begin
            push_tag.valid  = 1'b1;
            push_tag.mv.mvx = bus.cand_mvx;
            push_tag.mv.mvy = bus.cand_mvy;
            push_tag.last   = bus.cand_last;
        end
    end

    sad_tag_delay #(
        .DEPTH (SUM_LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (push_tag),
        .tag_out (dly_tag)
    );

    // Strict comparisons keep the earlier candidate on a full tie
    assign better = first_q
                 || (bus.sad < best_sad_q)
                 || ((bus.sad == best_sad_q) && (mv_cost(dly_tag.mv) < mv_cost(best_mv_q)));

    always_comb begin
        state_d      = state_q;
        best_mv_d    = best_mv_q;
        best_sad_d   = best_sad_q;
        best_cnt_d   = best_cnt_q;
        first_d      = first_q;
        best_valid_d = best_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SEARCH;
                    best_sad_d = '1;
                    best_mv_d  = '0;
                    best_cnt_d = '0;
                    first_d    = 1'b1;
                end
            end
            SEARCH: begin
                if (bus.cand_valid && bus.cand_last) state_d = DRAIN;
            end
            DRAIN: ;
            DONE: begin
                if (best_valid_q && bus.best_ready) begin
                    best_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dly_tag.valid) begin
            first_d    = 1'b0;
            best_cnt_d = (best_cnt_q == '1) ? best_cnt_q : best_cnt_q + 1'b1;
            if (better) begin
                best_mv_d  = dly_tag.mv;
                best_sad_d = bus.sad;
            end
            if (dly_tag.last) begin
                state_d      = DONE;
                best_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            best_mv_q    <= '0;
            best_sad_q   <= '0;
            best_cnt_q   <= '0;
            first_q      <= 1'b0;
            best_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_mv_q    <= best_mv_d;
            best_sad_q   <= best_sad_d;
            best_cnt_q   <= best_cnt_d;
            first_q      <= first_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.best_valid = best_valid_q;
    assign bus.best_mvx   = best_mv_q.mvx;
    assign bus.best_mvy   = best_mv_q.mvy;
    assign bus.best_sad   = best_sad_q;
    assign bus.best_cnt   = best_cnt_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select: emulates the adder tree SAD timing and checks a search-level model.
module tb_sad_min_select;
    import me_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [SAD_W-1:0] sad_sched [int];

    sad_min_select_if bus ();

    sad_min_select dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Adder tree stand-in: a candidate's SAD shows up SUM_LATENCY cycles later, noise otherwise
    always @(posedge clk) begin
        #1;
        if (sad_sched.exists(cyc)) bus.sad = sad_sched[cyc];
        else bus.sad = SAD_W'($urandom);
    end

    // Search-level model: collect accepted candidates, pick the winner when the last arrives
    typedef struct {
        int mx;
        int my;
        int sd;
    } cand_s;

    cand_s cands[$];
    int    phase = 0;  // 0 idle, 1 collecting, 2 awaiting result, 3 presenting result
    int    due = 0;
    int    e_mx = 0, e_my = 0, e_sd = 0, e_cnt = 0;

    function automatic int cost(input int x, input int y);
        return (x < 0 ? -x : x) + (y < 0 ? -y : y);
    endfunction

    task automatic resolve();
        int b = 0;
        for (int i = 1; i < cands.size(); i++) begin
            if (cands[i].sd < cands[b].sd ||
                (cands[i].sd == cands[b].sd &&
                 cost(cands[i].mx, cands[i].my) < cost(cands[b].mx, cands[b].my)))
                b = i;
        end
        e_mx  = cands[b].mx;
        e_my  = cands[b].my;
        e_sd  = cands[b].sd;
        e_cnt = (cands.size() > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : cands.size();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            phase = 0;
            cands.delete();
            chk("reset busy", int'(bus.busy), 0);
            chk("reset best_valid", int'(bus.best_valid), 0);
            chk("reset best_sad", int'(bus.best_sad), 0);
            chk("reset best_cnt", int'(bus.best_cnt), 0);
            chk("reset best_mvx", int'(bus.best_mvx), 0);
            chk("reset best_mvy", int'(bus.best_mvy), 0);
        end else begin
            if (phase == 2 && cyc == due) phase = 3;
            chk("busy", int'(bus.busy), int'(phase != 0));
            chk("best_valid", int'(bus.best_valid), int'(phase == 3));
            if (phase == 3) begin
                chk("best_mvx", int'(bus.best_mvx), e_mx);
                chk("best_mvy", int'(bus.best_mvy), e_my);
                chk("best_sad", int'(bus.best_sad), e_sd);
                chk("best_cnt", int'(bus.best_cnt), e_cnt);
            end
            case (phase)
                0: if (bus.start) begin
                    phase = 1;
                    cands.delete();
                end
                1: if (bus.cand_valid) begin
                    cands.push_back('{int'(bus.cand_mvx), int'(bus.cand_mvy),
                                      int'(sad_sched[cyc + SUM_LATENCY])});
                    if (bus.cand_last) begin
                        resolve();
                        phase = 2;
                        due   = cyc + SUM_LATENCY + 1;
                    end
                end
                3: if (bus.best_ready) phase = 0;
                default: ;
            endcase
        end
    end

    task automatic step(input logic st, input logic cv, input int mx, input int my,
                        input int sd, input logic lst, input logic rdy);
        @(posedge clk);
        #1;
        bus.start      = st;
        bus.cand_valid = cv;
        bus.cand_mvx   = MV_W'(mx);
        bus.cand_mvy   = MV_W'(my);
        bus.cand_last  = lst;
        bus.best_ready = rdy;
        if (cv) sad_sched[cyc + SUM_LATENCY] = SAD_W'(sd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic collect(input string tag, input int emx, input int emy, input int esd,
                           input int ecnt, input int edue);
        bit seen = 0;
        for (int n = 0; n < 64 && !seen; n++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (bus.best_valid) seen = 1;
        end
        chk({tag, " result seen"}, int'(seen), 1);
        if (seen) begin
            chk({tag, " latency"}, cyc, edue);
            chk({tag, " mvx"}, int'(bus.best_mvx), emx);
            chk({tag, " mvy"}, int'(bus.best_mvy), emy);
            chk({tag, " sad"}, int'(bus.best_sad), esd);
            chk({tag, " cnt"}, int'(bus.best_cnt), ecnt);
        end
    endtask

    // Hold the result with ready low (start pulsing), then accept it
    task automatic handshake(input int hold);
        for (int i = 0; i < hold; i++) begin
            step(i % 3 == 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk("hold busy", int'(bus.busy), 1);
            chk("hold best_valid", int'(bus.best_valid), 1);
        end
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    int t;

    initial begin
        bus.start = 0; bus.cand_valid = 0; bus.cand_mvx = '0; bus.cand_mvy = '0;
        bus.cand_last = 0; bus.best_ready = 0; bus.sad = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        idle(3);
        #3 rst_n = 1'b1;
        idle(2);

        // Three consecutive candidates
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 2, 300, 0, 0);
        step(0, 1, -3, 0, 120, 0, 0);
        step(0, 1, 4, 4, 450, 1, 0);
        t = cyc;
        collect("three", -3, 0, 120, 3, t + 6);
        handshake(0);

        // Equal SAD, lower cost wins
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 5, 100, 0, 0);
        step(0, 1, -1, 1, 100, 1, 0);
        t = cyc;
        collect("cost tie", -1, 1, 100, 2, t + 6);
        handshake(0);

        // Full tie keeps the earlier candidate
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, 0, 100, 0, 0);
        step(0, 1, 0, -2, 100, 1, 0);
        t = cyc;
        collect("full tie", 2, 0, 100, 2, t + 6);
        handshake(0);

        // Bubbles; candidate alongside start and unqualified last are ignored
        step(1, 1, 7, 7, 5, 0, 0);
        step(0, 1, 1, 1, 200, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, -2, 50, 0, 0);
        step(0, 1, 3, 3, 80, 1, 0);
        t = cyc;
        collect("bubbles", 2, -2, 50, 3, t + 6);
        handshake(10);

        // Start right after acceptance; extreme single candidate
        step(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("idle after accept", int'(bus.busy), 0);
        step(0, 1, -32, -32, 65535, 1, 0);
        t = cyc;
        collect("extreme", -32, -32, 65535, 1, t + 6);
        handshake(0);

        // Asynchronous reset while tags are in flight
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 3, 10, 0, 0);
        step(0, 1, 4, 4, 20, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort busy", int'(bus.busy), 0);
        chk("abort best_valid", int'(bus.best_valid), 0);
        chk("abort best_sad", int'(bus.best_sad), 0);
        chk("abort best_cnt", int'(bus.best_cnt), 0);
        idle(2);
        #1 rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 9, 9, 700, 1, 0);
        t = cyc;
        collect("post reset", 9, 9, 700, 1, t + 6);
        handshake(0);

        // Counter saturation over a long search
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1030; i++)
            step(0, 1, (i % 64) - 32, ((i / 64) % 64) - 32, 3000 + ((i * 7) % 1000),
                 i == 1029, 0);
        t = cyc;
        collect("saturate", 8, -17, 3000, 1023, t + 6);
        handshake(0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/sad_min_select.md
Name: sad_min_select

Overview:
- Motion-estimation stage directly downstream of the 256-pixel SAD adder tree (5-register pipeline, 16-bit sum per candidate).
- Tags each candidate motion vector on entry and delays the tag to line up with its SAD.
- Tracks the minimum SAD over one macroblock search and returns the best vector, SAD and candidate count through a valid/ready handshake.

Parameters:
- SUM_LATENCY, 5, cycles from candidate ad presented to the adder tree until its sum is valid; equals tag delay depth.
- SAD_W, 16, SAD width; must match adder tree output.
- MV_W, 6, signed two's-complement width of each MV component.
- CNT_W, 10, candidate counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a new search; accepted only in IDLE.
- cand_valid  in  1  candidate's ad presented to the adder tree this cycle.
- cand_mvx  in  MV_W  signed MV x of the candidate.
- cand_mvy  in  MV_W  signed MV y of the candidate.
- cand_last  in  1  final candidate of the search; qualified by cand_valid.
- sad  in  SAD_W  adder tree sum output.
- busy  out  1  high whenever state is not IDLE.
- best_valid  out  1  result available.
- best_ready  in  1  consumer accepts result.
- best_mvx  out  MV_W  winning MV x.
- best_mvy  out  MV_W  winning MV y.
- best_sad  out  SAD_W  winning SAD.
- best_cnt  out  CNT_W  number of candidates evaluated, saturating.

Behaviour:
- Reset values: all outputs 0, state IDLE, tag delay line cleared.
- FSM states: IDLE, SEARCH, DRAIN, DONE.
- IDLE to SEARCH on start. Same edge: best_sad=all-ones, best_mvx/y=0, best_cnt=0, first flag set.
- In IDLE, cand_valid is ignored. A candidate in the same cycle as start is also ignored; the first accepted candidate is in the cycle after start.
- SEARCH: each cand_valid pushes tag {valid, mvx, mvy, last} into the delay line.
- SEARCH to DRAIN when cand_valid and cand_last are both high. After that, cand_valid is ignored (pushes valid=0).
- Delay line shifts every cycle, with no stall, mirroring the adder tree. A tag pushed at cycle t is at the output at t+SUM_LATENCY, aligned with sad.
- When the delayed tag is valid, best is updated if any of these holds:
  - first flag is set;
  - sad < best_sad;
  - sad == best_sad and cost(mv) < cost(best), where cost = |mvx| + |mvy|, computed unsigned on MV_W+1 bits so that -2^(MV_W-1) is exact.
- On a full tie (equal SAD and equal cost), the earlier candidate is kept.
- Every delayed valid tag clears first and increments best_cnt, saturating at 2^CNT_W - 1.
- When the delayed tag has last set, its compare completes that cycle and the state moves to DONE. best_valid rises the following cycle. Latency: last candidate at t gives best_valid at t+SUM_LATENCY+1.
- DONE: best_valid=1 and best_* held stable until best_valid and best_ready are both high. Then best_valid drops and the state returns to IDLE next cycle.
- start is ignored while busy.
- cand_last in IDLE is ignored.
- A search with a single candidate (first cand_valid carries last) is legal.
- Asynchronous reset mid-search aborts immediately. Outputs and delay line return to reset values and no result is produced.
- The sad input is ignored when the delayed tag is invalid. Bubbles in cand_valid are allowed.

Decomposition:
- Package me_pkg holds:
  - SAD_W, MV_W, SUM_LATENCY constants;
  - packed struct mv_t {mvx, mvy};
  - packed struct sad_tag_t {valid, mv_t mv, last};
  - enum sel_state_t {IDLE, SEARCH, DRAIN, DONE};
  - function mv_cost(mv_t).
- Sub-module sad_tag_delay: SUM_LATENCY-deep shift register of sad_tag_t, asynchronously reset to all zeros.

Test Plan:
- Reset: assert rst_n=0 mid-search -> busy=0, best_valid=0, best_sad=0, best_cnt=0; no result appears after release.
- Three candidates in consecutive cycles, SADs 300, 120, 450, MVs (1,2), (-3,0), (4,4), last on the third -> best_valid at t3+6, best_mv=(-3,0), best_sad=120, best_cnt=3.
- Tie on cost: SADs 100 at (5,5) then 100 at (-1,1) -> best_mv=(-1,1). Full tie: 100 at (2,0) then 100 at (0,-2) -> best_mv=(2,0).
- Bubbles: candidates at cycles 1, 4, 5 with cand_valid low between, start and cand_valid both high at cycle 0 -> cycle 0 candidate ignored, best_cnt=3, SAD alignment correct.
- Backpressure: best_ready low for 10 cycles -> outputs stable, busy=1, start pulses ignored; best_ready=1 -> IDLE next cycle, new start accepted.
- Extremes: single candidate, sad=16'hFFFF, mv=(-32,-32), last on the first -> best_sad=16'hFFFF, best_mv=(-32,-32), best_cnt=1.
